// File: rtl/cmp_loader_pkg.sv
// Shared definitions for the comparator operand loader: default widths and
// the 2-bit state encoding used by the loader FSM.
package cmp_loader_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int CNT_W_DEF = 8;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_LOAD_A = 2'd0;
  localparam logic [1:0] ST_LOAD_B = 2'd1;
  localparam logic [1:0] ST_CMP    = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

endpackage

// File: rtl/cmp_loader_if.sv
// Operand stream and result handshake bundle between producer/consumer and loader.
// Both channels are valid/ready: a transfer happens on a rising edge where valid
// and ready are both 1; valid must not drop and data must not change until then.
interface cmp_loader_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             res_valid;
  logic             res_ready;
  logic             res_eq;

  modport master (
    output in_data, in_valid, res_ready,
    input  in_ready, res_valid, res_eq
  );

  modport slave (
    input  in_data, in_valid, res_ready,
    output in_ready, res_valid, res_eq
  );
endinterface

// File: rtl/cmp_loader_match_counter.sv
// Saturating match counter; a synchronous clear takes priority over an increment.
module match_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end
endmodule

// File: rtl/cmp_loader.sv
// Pairs incoming words as A then B, holds them on the external comparator,
// captures its equality output one cycle later and counts matches.
module cmp_loader
  import cmp_loader_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  cmp_loader_if.slave      bus,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  input  logic             eq,
  output logic [CNT_W-1:0] match_count,
  input  logic             clr_cnt,
  output logic             busy,
  output logic [1:0]       fsm_state
);
  state_t state;
  logic   res_valid_q;
  logic   res_eq_q;
  logic   take;
  logic   inc;

  // Ready depends on state only; gating with rst keeps it low while reset is held.
  assign bus.in_ready  = !rst && ((state == ST_LOAD_A) || (state == ST_LOAD_B));
  assign bus.res_valid = res_valid_q;
  assign bus.res_eq    = res_eq_q;
  assign busy          = (state != ST_LOAD_A);
  assign fsm_state     = state;
  assign take          = bus.in_valid && bus.in_ready;
  assign inc           = (state == ST_CMP) && eq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_LOAD_A;
      op_a        <= '0;
      op_b        <= '0;
      res_eq_q    <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_LOAD_A: begin
          if (take) begin
            op_a  <= bus.in_data;
            state <= ST_LOAD_B;
          end
        end
        ST_LOAD_B: begin
          if (take) begin
            op_b  <= bus.in_data;
            state <= ST_CMP;
          end
        end
        // Operands have been stable for a full cycle, so eq has settled.
        ST_CMP: begin
          res_eq_q    <= eq;
          res_valid_q <= 1'b1;
          state       <= ST_HOLD;
        end
        ST_HOLD: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state       <= ST_LOAD_A;
          end
        end
        default: state <= ST_LOAD_A;
      endcase
    end
  end

  match_counter #(.CNT_W(CNT_W)) u_match_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc),
    .clr   (clr_cnt),
    .count (match_count)
  );
endmodule

// File: tb/tb_cmp_loader.sv
// Bench for cmp_loader with a transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_cmp_loader;
  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             eq;
  logic [CNT_W-1:0] match_count;
  logic             clr_cnt;
  logic             busy;
  logic [1:0]       fsm_state;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  bit started  = 0;

  cmp_loader_if #(.WIDTH(WIDTH)) bus ();

  cmp_loader #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .op_a        (op_a),
    .op_b        (op_b),
    .eq          (eq),
    .match_count (match_count),
    .clr_cnt     (clr_cnt),
    .busy        (busy),
    .fsm_state   (fsm_state)
  );

  // External equality comparator
  assign eq = (op_a == op_b);

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Model: words staged so far, a pending settle cycle, a pending result
  int               m_have;
  bit               m_settle;
  bit               m_pend;
  logic             m_res;
  logic [WIDTH-1:0] m_a, m_b;
  int               m_cnt;
  logic             exp_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_have = 0; m_settle = 0; m_pend = 0; m_res = 1'b0;
      m_a = '0; m_b = '0; m_cnt = 0;
      exp_q.delete();
    end else begin
      if (m_pend) begin
        if (bus.res_ready) m_pend = 0;
      end else if (m_settle) begin
        m_settle = 0;
        m_pend   = 1;
        if (exp_q.size() == 0) chk("model_queue_empty", 0, 1);
        else m_res = exp_q.pop_front();
        if (m_res && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      end else if (bus.in_valid) begin
        if (m_have == 0) begin
          m_a = bus.in_data; m_have = 1;
        end else begin
          m_b = bus.in_data; m_have = 0; m_settle = 1;
          exp_q.push_back(m_a == m_b);
        end
      end
      if (clr_cnt) m_cnt = 0;
    end
  end

  // Compare process
  always @(posedge clk) begin
    #2;
    if (started && !rst) begin
      chk("cyc_in_ready", bus.in_ready, !m_settle && !m_pend);
      chk("cyc_busy", busy, (m_have != 0) || m_settle || m_pend);
      chk("cyc_res_valid", bus.res_valid, m_pend);
      chk("cyc_res_eq", bus.res_eq, m_res);
      chk("cyc_op_a", op_a, m_a);
      chk("cyc_op_b", op_b, m_b);
      chk("cyc_match_count", match_count, m_cnt);
    end
  end

  // Driver tasks
  task automatic send(input logic [WIDTH-1:0] d);
    bit done;
    done = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.in_ready) begin
        @(posedge clk);
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    #1 bus.in_valid = 1'b0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    logic [WIDTH-1:0] x;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.res_ready = 1'b1; clr_cnt = 1'b0;
    #3;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_count", match_count, 0);
    chk("rst_op_a", op_a, 0);
    wait_neg(2);
    rst = 1'b0;
    started = 1;
    #1 chk("post_rst_in_ready", bus.in_ready, 1);

    // Mismatch pair
    send(4'b0110);
    send(4'b0111);
    wait_neg(1);
    chk("mm_cmp_no_valid", bus.res_valid, 0);
    wait_neg(1);
    chk("mm_res_valid", bus.res_valid, 1);
    chk("mm_res_eq", bus.res_eq, 0);
    chk("mm_op_a", op_a, 4'b0110);
    chk("mm_op_b", op_b, 4'b0111);
    chk("mm_count", match_count, 0);
    wait_neg(1);
    chk("mm_pulse_end", bus.res_valid, 0);

    // Match pair
    send(4'b0111);
    send(4'b0111);
    wait_neg(2);
    chk("m_res_eq", bus.res_eq, 1);
    chk("m_count", match_count, 1);
    wait_neg(1);
    chk("m_busy_idle", busy, 0);

    // Backpressure
    bus.res_ready = 1'b0;
    send(4'b0011);
    send(4'b0011);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'b1010;
    wait_neg(1);
    chk("bp_cmp_in_ready", bus.in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", bus.res_valid, 1);
      chk("bp_hold_eq", bus.res_eq, 1);
      chk("bp_hold_in_ready", bus.in_ready, 0);
      chk("bp_hold_op_a", op_a, 4'b0011);
    end
    bus.res_ready = 1'b1;
    wait_neg(1);
    chk("bp_release_valid", bus.res_valid, 0);
    chk("bp_release_op_a", op_a, 4'b0011);
    wait_neg(1);
    chk("bp_new_a", op_a, 4'b1010);
    chk("bp_state_load_b", fsm_state, 1);
    bus.in_valid = 1'b0;
    send(4'b1010);
    wait_neg(2);
    chk("bp_pair_eq", bus.res_eq, 1);
    chk("bp_pair_count", match_count, 3);

    // Saturation
    wait_neg(1);
    clr_cnt = 1'b1;
    wait_neg(1);
    clr_cnt = 1'b0;
    chk("clr_idle_count", match_count, 0);
    for (int i = 0; i < 255; i++) begin
      x = WIDTH'($urandom_range(0, 15));
      send(x);
      send(x);
    end
    wait_neg(3);
    chk("sat_255", match_count, 255);
    send(4'b1001);
    send(4'b1001);
    wait_neg(3);
    chk("sat_hold_255", match_count, 255);

    // Clear in the CMP cycle of a matching pair
    send(4'b0101);
    send(4'b0101);
    clr_cnt = 1'b1;
    @(posedge clk);
    #1 clr_cnt = 1'b0;
    wait_neg(1);
    chk("clr_cmp_count", match_count, 0);
    chk("clr_cmp_res_eq", bus.res_eq, 1);
    chk("clr_cmp_valid", bus.res_valid, 1);

    // Reset in LOAD_B
    wait_neg(1);
    send(4'b1111);
    @(negedge clk);
    chk("rb_state_load_b", fsm_state, 1);
    rst = 1'b1;
    #2;
    chk("rb_in_ready", bus.in_ready, 0);
    chk("rb_op_a", op_a, 0);
    chk("rb_state", fsm_state, 0);
    chk("rb_res_valid", bus.res_valid, 0);
    #1 rst = 1'b0;
    wait_neg(1);
    chk("rb_after_in_ready", bus.in_ready, 1);
    chk("rb_after_valid", bus.res_valid, 0);
    chk("rb_after_busy", busy, 0);
    send(4'b0000);
    send(4'b0000);
    wait_neg(2);
    chk("rb_pair_valid", bus.res_valid, 1);
    chk("rb_pair_eq", bus.res_eq, 1);
    chk("rb_pair_count", match_count, 1);
    wait_neg(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
